seven_seg_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment scan driver for N digits. It is the next generation of the clock's fixed 6-digit driver. It adds a scan-rate prescaler, frame-coherent input snapshots, anti-ghosting guard blanking, per-digit blanking, blinking, decimal-point masks, leading-zero suppression, optional hex decode and configurable output polarity. It sits between the timekeeping/settings logic and the board's segment and select pins.

---
 rtl/seven_seg_scan_driver.sv | 156 +++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with frame-coherent input
// snapshots, guard blanking, blinking, leading-zero suppression and pin polarity.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_DIV       = 1000,
  parameter int GUARD          = 1,
  parameter int BLINK_FRAMES   = 250,
  parameter bit HEX_EN         = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  output logic [7:0]              seg_data,
  output logic [NUM_DIGITS-1:0]   seg_sel,
  output logic                    frame_start
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [7:0]            SEG_OFF = {8{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW}};

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   blink;
    logic                    lz;
  } snap_t;

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_off_q, blink_off_d;
  snap_t                 snap_q, snap_d;
  logic [7:0]            seg_data_q, seg_data_d;
  logic [NUM_DIGITS-1:0] seg_sel_q, seg_sel_d;
  logic                  frame_start_q, frame_start_d;

  logic                  slot_end, frame_end;
  logic [3:0]            code [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_dark;
  logic                  seen_nz;
  logic                  dark;
  logic [7:0]            seg_raw;
  logic [NUM_DIGITS-1:0] sel_raw;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'h0:    glyph = 7'h3F;
      4'h1:    glyph = 7'h06;
      4'h2:    glyph = 7'h5B;
      4'h3:    glyph = 7'h4F;
      4'h4:    glyph = 7'h66;
      4'h5:    glyph = 7'h6D;
      4'h6:    glyph = 7'h7D;
      4'h7:    glyph = 7'h07;
      4'h8:    glyph = 7'h7F;
      4'h9:    glyph = 7'h6F;
      4'hA:    glyph = HEX_EN ? 7'h77 : 7'h00;
      4'hB:    glyph = HEX_EN ? 7'h7C : 7'h00;
      4'hC:    glyph = HEX_EN ? 7'h39 : 7'h00;
      4'hD:    glyph = HEX_EN ? 7'h5E : 7'h00;
      4'hE:    glyph = HEX_EN ? 7'h79 : 7'h00;
      default: glyph = HEX_EN ? 7'h71 : 7'h00;
    endcase
  endfunction

  // Scan position, blink phase and frame-boundary snapshot.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    presc_d     = presc_q + 1'b1;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    snap_d      = snap_q;
    slot_end    = (presc_q == PW'(SCAN_DIV - 1));
    frame_end   = slot_end && (idx_q == IW'(NUM_DIGITS - 1));
    if (slot_end) begin
      presc_d = '0;
      idx_d   = frame_end ? '0 : idx_q + 1'b1;
    end
    if (frame_end) begin
      snap_d = '{digits: digits, dp: dp_mask, blank: blank_mask,
                 blink: blink_mask, lz: lz_en};
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Leading zeros: walk from the most significant digit until a nonzero code.
  always_comb begin
    seen_nz = 1'b0;
    lz_dark = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      code[i] = snap_q.digits[4*i +: 4];
      if (code[i] != 4'h0) seen_nz = 1'b1;
      lz_dark[i] = snap_q.lz && !seen_nz && (i != 0);
    end
  end

  always_comb begin
    dark    = snap_q.blank[idx_q] || (blink_off_q && snap_q.blink[idx_q]);
    seg_raw = '0;
    sel_raw = '0;
    if (presc_q >= PW'(GUARD)) begin
      sel_raw[idx_q] = 1'b1;
      if (!dark) begin
        seg_raw = {snap_q.dp[idx_q], lz_dark[idx_q] ? 7'h00 : glyph(code[idx_q])};
      end
    end
    seg_data_d    = seg_raw ^ SEG_OFF;
    seg_sel_d     = sel_raw ^ SEL_OFF;
    frame_start_d = (presc_q == '0) && (idx_q == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_off_q   <= 1'b0;
      snap_q        <= '0;
      seg_data_q    <= SEG_OFF;
      seg_sel_q     <= SEL_OFF;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_off_q   <= blink_off_d;
      snap_q        <= snap_d;
      seg_data_q    <= seg_data_d;
      seg_sel_q     <= seg_sel_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg_data    = seg_data_q;
  assign seg_sel     = seg_sel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: two polarity/decode variants driven in parallel
// and compared every cycle against a tick-arithmetic reference model.
module tb_seven_seg_scan_driver;
  localparam int N  = 4;
  localparam int SD = 4;
  localparam int G  = 1;
  localparam int BF = 2;
  localparam int FL = N * SD;

  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                         7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                         7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct packed {
    logic [4*N-1:0] digits;
    logic [N-1:0]   dp;
    logic [N-1:0]   blank;
    logic [N-1:0]   blink;
    logic           lz;
  } snap_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [4*N-1:0] digits;
  logic [N-1:0]   dp_mask, blank_mask, blink_mask;
  logic           lz_en;
  logic [7:0]     seg_a, seg_b;
  logic [N-1:0]   sel_a, sel_b;
  logic           fs_a, fs_b;

  int    compared   = 0;
  int    mismatched = 0;
  int    s;
  snap_t snap;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS(N), .SCAN_DIV(SD), .GUARD(G), .BLINK_FRAMES(BF),
    .HEX_EN(1'b1), .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_mask(dp_mask),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_en(lz_en),
    .seg_data(seg_a), .seg_sel(sel_a), .frame_start(fs_a)
  );

  seven_seg_scan_driver #(
    .NUM_DIGITS(N), .SCAN_DIV(SD), .GUARD(G), .BLINK_FRAMES(BF),
    .HEX_EN(1'b0), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_mask(dp_mask),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_en(lz_en),
    .seg_data(seg_b), .seg_sel(sel_b), .frame_start(fs_b)
  );

  // Expected segment byte for the output produced from model tick t.
  function automatic logic [7:0] exp_seg(input int t, input bit hex, input bit seg_al);
    int         p, idx, frame;
    logic [3:0] c;
    logic [7:0] v;
    bit         blink_off, lead;
    p     = t % SD;
    idx   = (t / SD) % N;
    frame = t / FL;
    v     = 8'h00;
    if (p >= G) begin
      c         = snap.digits[idx*4 +: 4];
      blink_off = ((frame / BF) % 2) == 1;
      if (!(snap.blank[idx] || (blink_off && snap.blink[idx]))) begin
        lead = snap.lz && (idx != 0);
        for (int j = idx; j < N; j++)
          if (snap.digits[j*4 +: 4] != 4'h0) lead = 1'b0;
        v[7]   = snap.dp[idx];
        v[6:0] = (lead || (!hex && c > 4'h9)) ? 7'h00 : GLYPH[c];
      end
    end
    return seg_al ? ~v : v;
  endfunction

  function automatic logic [N-1:0] exp_sel(input int t, input bit sel_al);
    logic [N-1:0] v;
    v = '0;
    if ((t % SD) >= G) v[(t / SD) % N] = 1'b1;
    return sel_al ? ~v : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s tick=%0d: observed %0h expected %0h", tag, s, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".seg_a"}, 32'(seg_a), 32'h00);
    check({tag, ".sel_a"}, 32'(sel_a), 32'hF);
    check({tag, ".fs_a"},  32'(fs_a),  32'h0);
    check({tag, ".seg_b"}, 32'(seg_b), 32'hFF);
    check({tag, ".sel_b"}, 32'(sel_b), 32'h0);
    check({tag, ".fs_b"},  32'(fs_b),  32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check("seg_a", 32'(seg_a), 32'(exp_seg(s, 1'b1, 1'b0)));
    check("sel_a", 32'(sel_a), 32'(exp_sel(s, 1'b1)));
    check("fs_a",  32'(fs_a),  32'((s % FL) == 0));
    check("seg_b", 32'(seg_b), 32'(exp_seg(s, 1'b0, 1'b1)));
    check("sel_b", 32'(sel_b), 32'(exp_sel(s, 1'b0)));
    check("fs_b",  32'(fs_b),  32'((s % FL) == 0));
    if ((s % FL) == FL - 1)
      snap = '{digits: digits, dp: dp_mask, blank: blank_mask, blink: blink_mask, lz: lz_en};
    s++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    s     = 0;
    snap  = '0;
  endtask

  initial begin
    logic [31:0] r;
    rst_n      = 1'b0;
    digits     = '0;
    dp_mask    = '0;
    blank_mask = '0;
    blink_mask = '0;
    lz_en      = 1'b0;
    s          = 0;
    snap       = '0;
    @(posedge clk);
    #1;
    check_idle("reset");
    release_reset();

    // Zero snapshot frame, then 1234 decode, then mid-frame tearing attempt.
    digits = 16'h1234;
    run(FL);
    run(FL + SD + 2);
    digits = 16'h9999;
    run(2 * FL);

    // Leading zeros with decimal point, then all-zero display.
    lz_en   = 1'b1;
    digits  = 16'h0050;
    dp_mask = 4'b0100;
    run(2 * FL);
    digits  = 16'h0000;
    dp_mask = 4'b0000;
    run(2 * FL);

    // Blank mask must not change which digits count as leading zeros.
    digits     = 16'h0105;
    blank_mask = 4'b0100;
    dp_mask    = 4'b1000;
    run(2 * FL);

    // Blink over several phases, then hex digit A.
    lz_en      = 1'b0;
    blank_mask = '0;
    dp_mask    = '0;
    digits     = 16'h1234;
    blink_mask = 4'b0001;
    run(6 * FL);
    blink_mask = '0;
    digits     = 16'hFEDA;
    run(2 * FL);
    digits     = 16'hCB0A;
    run(2 * FL);

    // Randomized inputs changing at arbitrary cycles.
    for (int k = 0; k < 40; k++) begin
      r          = $urandom;
      digits     = r[15:0] >> (4 * $urandom_range(0, 4));
      dp_mask    = 4'($urandom);
      blank_mask = 4'($urandom & $urandom);
      blink_mask = 4'($urandom);
      lz_en      = 1'($urandom_range(0, 1));
      run($urandom_range(1, 24));
    end

    // Reset asserted mid-slot: outputs go idle at once, scan restarts at slot 0.
    run(SD + 2);
    rst_n = 1'b0;
    #1;
    check_idle("midreset");
    @(posedge clk);
    #1;
    check_idle("midreset_hold");
    release_reset();
    digits = 16'h1234;
    run(3 * FL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
